// File: rtl/prbs7_checker_if.sv
// Serial PRBS7 receive-side bundle: the bit stream and its controls in,
// lock/error status out.
interface prbs7_checker_if;
  logic        din;
  logic        din_valid;
  logic        err_clr;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  modport master (
    output din, din_valid, err_clr,
    input  locked, bit_err, err_cnt, state
  );

  modport slave (
    input  din, din_valid, err_clr,
    output locked, bit_err, err_cnt, state
  );
endinterface

// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) receive checker: self-synchronising search, verify run,
// then flywheel lock with windowed loss-of-lock detection and error counting.
module prbs7_checker #(
  parameter int LOCK_CNT    = 16,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic           clkin,
  input  logic           rst,
  prbs7_checker_if.slave io_bus
);

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_THRESH - 1);

  logic [1:0]    r_state,     w_state_next;
  logic [6:0]    r_s,         w_s_next;
  logic [2:0]    r_fill_cnt,  w_fill_next;
  logic [MW-1:0] r_match_cnt, w_match_next;
  logic [WW-1:0] r_win_cnt,   w_win_next;
  logic [EW-1:0] r_win_err,   w_win_err_next;
  logic [15:0]   r_err_cnt,   w_err_cnt_next;
  logic          r_locked,    w_locked_next;
  logic          r_bit_err,   w_bit_err_next;

  logic       w_p;
  logic       w_miss;
  logic       w_count_err;
  logic [6:0] w_s_din;

  assign w_p         = r_s[6] ^ r_s[5];
  assign w_miss      = io_bus.din ^ w_p;
  assign w_s_din     = {r_s[5:0], io_bus.din};
  assign w_count_err = io_bus.din_valid && (r_state == ST_LOCKED) && w_miss;

  always_comb begin
    w_state_next   = r_state;
    w_s_next       = r_s;
    w_fill_next    = r_fill_cnt;
    w_match_next   = r_match_cnt;
    w_win_next     = r_win_cnt;
    w_win_err_next = r_win_err;
    w_locked_next  = r_locked;
    w_bit_err_next = 1'b0;

    if (io_bus.din_valid) begin
      case (r_state)
        ST_SEARCH: begin
          w_s_next = w_s_din;
          if (r_fill_cnt == 3'd6) begin
            w_fill_next = 3'd0;
            // An all-zero register is the LFSR lock-up state; keep searching.
            if (w_s_din != 7'h00) begin
              w_state_next = ST_VERIFY;
              w_match_next = '0;
            end
          end else begin
            w_fill_next = r_fill_cnt + 3'd1;
          end
        end

        ST_VERIFY: begin
          w_s_next = w_s_din;
          if (w_miss) begin
            w_state_next = ST_SEARCH;
            w_fill_next  = 3'd0;
            w_match_next = '0;
          end else if (r_match_cnt == MATCH_LAST) begin
            w_state_next   = ST_LOCKED;
            w_locked_next  = 1'b1;
            w_match_next   = '0;
            w_win_next     = '0;
            w_win_err_next = '0;
          end else begin
            w_match_next = r_match_cnt + MW'(1);
          end
        end

        ST_LOCKED: begin
          // Flywheel: feed back our own prediction so line errors never
          // pollute the reference sequence.
          w_s_next       = {r_s[5:0], w_p};
          w_bit_err_next = w_miss;
          if (w_miss && (r_win_err == ERR_LAST)) begin
            w_state_next   = ST_SEARCH;
            w_locked_next  = 1'b0;
            w_fill_next    = 3'd0;
            w_match_next   = '0;
            w_win_next     = '0;
            w_win_err_next = '0;
          end else if (r_win_cnt == WIN_LAST) begin
            w_win_next     = '0;
            w_win_err_next = '0;
          end else begin
            w_win_next = r_win_cnt + WW'(1);
            if (w_miss) begin
              w_win_err_next = r_win_err + EW'(1);
            end
          end
        end

        default: begin
          w_state_next   = ST_SEARCH;
          w_locked_next  = 1'b0;
          w_fill_next    = 3'd0;
          w_match_next   = '0;
          w_win_next     = '0;
          w_win_err_next = '0;
        end
      endcase
    end
  end

  // err_clr wins over the increment but still counts an error on the same bit.
  always_comb begin
    w_err_cnt_next = r_err_cnt;
    if (io_bus.err_clr) begin
      w_err_cnt_next = {15'd0, w_count_err};
    end else if (w_count_err && (r_err_cnt != 16'hFFFF)) begin
      w_err_cnt_next = r_err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_s         <= 7'h00;
      r_fill_cnt  <= 3'd0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_cnt   <= 16'd0;
      r_locked    <= 1'b0;
      r_bit_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_fill_cnt  <= w_fill_next;
      r_match_cnt <= w_match_next;
      r_win_cnt   <= w_win_next;
      r_win_err   <= w_win_err_next;
      r_err_cnt   <= w_err_cnt_next;
      r_locked    <= w_locked_next;
      r_bit_err   <= w_bit_err_next;
    end
  end

  assign io_bus.state   = r_state;
  assign io_bus.locked  = r_locked;
  assign io_bus.bit_err = r_bit_err;
  assign io_bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: directed lock/error/reset scenarios plus a random
// run, all compared cycle-by-cycle against a history-based reference model.
module tb_prbs7_checker;
  localparam int LOCK_CNT    = 16;
  localparam int WIN         = 64;
  localparam int LOSS_THRESH = 8;

  logic clkin = 1'b0;
  logic rst;

  prbs7_checker_if bus_if ();

  prbs7_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .WIN        (WIN),
    .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clkin (clkin),
    .rst   (rst),
    .io_bus(bus_if)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keeps the last 7 sequence bits oldest-first as a queue.
  bit m_hist[$];
  int m_state, m_fill, m_match, m_win, m_werr, m_errcnt;
  bit m_biterr;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_errcnt = 0; m_biterr = 1'b0;
  endtask

  task automatic push_bit(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit d, input bit v, input bit clr);
    bit p, err;
    int ones;
    err = 1'b0;
    m_biterr = 1'b0;
    if (v) begin
      p = m_hist[0] ^ m_hist[1];
      if (m_state == 0) begin
        push_bit(d);
        m_fill++;
        if (m_fill == 7) begin
          m_fill = 0;
          ones = 0;
          foreach (m_hist[i]) ones += int'(m_hist[i]);
          if (ones != 0) begin m_state = 1; m_match = 0; end
        end
      end else if (m_state == 1) begin
        push_bit(d);
        if (d != p) begin
          m_state = 0; m_fill = 0; m_match = 0;
        end else begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_state = 2; m_match = 0; m_win = 0; m_werr = 0; end
        end
      end else begin
        push_bit(p);
        if (d != p) begin err = 1'b1; m_biterr = 1'b1; m_werr++; end
        if (m_werr == LOSS_THRESH) begin
          m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        end else begin
          m_win++;
          if (m_win == WIN) begin m_win = 0; m_werr = 0; end
        end
      end
    end
    if (clr) m_errcnt = err ? 1 : 0;
    else if (err && m_errcnt < 65535) m_errcnt++;
  endtask

  // Stimulus-side PRBS7 generator.
  logic [6:0] g;
  task automatic gen_next(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic cycle(input logic d, input logic v, input logic clr, input string tag);
    bus_if.din = d; bus_if.din_valid = v; bus_if.err_clr = clr;
    model_step(d, v, clr);
    @(posedge clkin); #1;
    check_val({tag, ".state"},   32'(bus_if.state),   32'(m_state));
    check_val({tag, ".locked"},  32'(bus_if.locked),  32'(m_state == 2));
    check_val({tag, ".bit_err"}, 32'(bus_if.bit_err), 32'(m_biterr));
    check_val({tag, ".err_cnt"}, 32'(bus_if.err_cnt), 32'(m_errcnt));
    @(negedge clkin);
  endtask

  task automatic send_bit(input logic inject, input logic clr, input string tag);
    logic b;
    gen_next(b);
    cycle(b ^ inject, 1'b1, clr, tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, ".state"},   32'(bus_if.state),   32'd0);
    check_val({tag, ".locked"},  32'(bus_if.locked),  32'd0);
    check_val({tag, ".bit_err"}, 32'(bus_if.bit_err), 32'd0);
    check_val({tag, ".err_cnt"}, 32'(bus_if.err_cnt), 32'd0);
  endtask

  // Asserts reset between clock edges so the clear must be asynchronous.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero_outputs(tag);
    model_reset();
    g = 7'h01;
    @(negedge clkin);
    rst = 1'b0;
  endtask

  task automatic acquire(input string tag);
    for (int k = 0; k < 7 + LOCK_CNT; k++) send_bit(1'b0, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.din = 1'b0; bus_if.din_valid = 1'b0; bus_if.err_clr = 1'b0;
    model_reset();
    g = 7'h01;
    #2 check_zero_outputs("por");
    @(negedge clkin);
    rst = 1'b0;

    // Continuous valid stream from seed 01.
    for (int k = 1; k <= 23; k++) begin
      send_bit(1'b0, 1'b0, "lock");
      if (k == 7)  check_val("lock.verify_entry", 32'(bus_if.state), 32'd1);
      if (k == 22) check_val("lock.not_early", 32'(bus_if.locked), 32'd0);
    end
    check_val("lock.at23", 32'(bus_if.locked), 32'd1);
    check_val("lock.state", 32'(bus_if.state), 32'd2);
    $display("scenario continuous_lock done, errors=%0d", n_errors);

    // Single inverted bit while locked.
    send_bit(1'b1, 1'b0, "single");
    check_val("single.pulse", 32'(bus_if.bit_err), 32'd1);
    check_val("single.cnt", 32'(bus_if.err_cnt), 32'd1);
    for (int k = 0; k < 20; k++) send_bit(1'b0, 1'b0, "single_after");
    check_val("single.locked", 32'(bus_if.locked), 32'd1);
    $display("scenario single_error done, errors=%0d", n_errors);

    // Valid toggling 1,0,1,0.
    do_reset("rst_toggle");
    for (int c = 1; c <= 46; c++) begin
      if (c % 2 == 1) send_bit(1'b0, 1'b0, "toggle");
      else cycle(1'($urandom_range(1)), 1'b0, 1'b0, "toggle_idle");
      if (c == 44) check_val("toggle.not_early", 32'(bus_if.locked), 32'd0);
      if (c == 45) check_val("toggle.at45", 32'(bus_if.locked), 32'd1);
    end
    $display("scenario valid_toggle done, errors=%0d", n_errors);

    // Eight errors in one window force loss of lock.
    do_reset("rst_loss");
    acquire("loss_acq");
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0, "loss");
    check_val("loss.locked", 32'(bus_if.locked), 32'd0);
    check_val("loss.state", 32'(bus_if.state), 32'd0);
    check_val("loss.cnt", 32'(bus_if.err_cnt), 32'd8);
    $display("scenario loss_of_lock done, errors=%0d", n_errors);

    // Seven errors per window, three windows: lock holds.
    do_reset("rst_win");
    acquire("win_acq");
    for (int i = 0; i < 3 * WIN; i++) send_bit(1'((i % WIN) < 7), 1'b0, "win");
    check_val("win.locked", 32'(bus_if.locked), 32'd1);
    check_val("win.cnt", 32'(bus_if.err_cnt), 32'd21);
    $display("scenario window_errors done, errors=%0d", n_errors);

    // All-zero input never leaves SEARCH.
    do_reset("rst_zero");
    for (int k = 0; k < 40; k++) cycle(1'b0, 1'b1, 1'b0, "zero");
    check_val("zero.state", 32'(bus_if.state), 32'd0);
    check_val("zero.locked", 32'(bus_if.locked), 32'd0);
    // Inverted 10th VERIFY bit drops back to SEARCH.
    do_reset("rst_v10");
    for (int k = 0; k < 16; k++) send_bit(1'b0, 1'b0, "v10");
    check_val("v10.verify", 32'(bus_if.state), 32'd1);
    send_bit(1'b1, 1'b0, "v10_bad");
    check_val("v10.search", 32'(bus_if.state), 32'd0);
    check_val("v10.locked", 32'(bus_if.locked), 32'd0);
    $display("scenario zero_and_verify_miss done, errors=%0d", n_errors);

    // Reset while locked with err_cnt=5.
    do_reset("rst_mid");
    acquire("mid_acq");
    for (int k = 0; k < 5; k++) begin
      send_bit(1'b1, 1'b0, "mid_err");
      send_bit(1'b0, 1'b0, "mid_ok");
    end
    check_val("mid.cnt5", 32'(bus_if.err_cnt), 32'd5);
    do_reset("mid_async");
    acquire("reacq");
    check_val("reacq.locked", 32'(bus_if.locked), 32'd1);
    // err_clr coinciding with a counted error.
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0, "clr_pre");
    send_bit(1'b1, 1'b1, "clr_err");
    check_val("clr.cnt1", 32'(bus_if.err_cnt), 32'd1);
    $display("scenario reset_and_clear done, errors=%0d", n_errors);

    // Random traffic: gaps, sparse errors, periodic bursts, occasional clears.
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      logic v, inj, clr;
      v   = ($urandom_range(3) != 0);
      inj = (((i % 500) >= 300) && ((i % 500) < 312)) || ($urandom_range(19) == 0);
      clr = ($urandom_range(49) == 0);
      if (v) send_bit(inj, clr, "rand");
      else cycle(1'($urandom_range(1)), 1'b0, clr, "rand_idle");
    end
    $display("scenario random done, errors=%0d", n_errors);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
